// File: rtl/CPU_config.sv
// Shared CPU configuration: datapath width and the fetch response record
// carried through the responder's delay pipeline and response FIFO.
package CPU_config;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } fetch_resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO of fetch responses; pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module resp_fifo
  import CPU_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  fetch_resp_t i_push_data,
  input  logic        i_pop,
  output fetch_resp_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  fetch_resp_t r_mem [DEPTH];
  logic        w_do_pop;

  assign w_do_pop = i_pop & ~o_empty;

  // NOTE: all state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; o_empty masks whatever it holds after reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction-fetch interface: read-only word array,
// fixed-latency delay pipeline, credit-limited request acceptance, response FIFO.
module imem_responder
  import CPU_config::*;
#(
  parameter int              MEM_WORDS = 1024,
  parameter int              LATENCY   = 2,
  parameter int              MAX_OUTST = 4,
  parameter logic [XLEN-1:0] INIT_IMAGE [MEM_WORDS] = '{default: '0}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic                r_req_ready;
  logic [CW-1:0]       r_credits;
  logic [CW-1:0]       w_credits_nxt;
  logic [LATENCY-1:0]  r_pipe_vld;
  fetch_resp_t         r_pipe [LATENCY];

  logic                w_accept;
  logic                w_pop;
  logic                w_err;
  logic [AW-1:0]       w_idx;
  logic                w_push;
  fetch_resp_t         w_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;

  assign req_ready = r_req_ready;
  assign w_accept  = req_valid & r_req_ready;
  assign w_pop     = resp_valid & resp_ready;

  // Misaligned, or any address bit above the array's byte range is set.
  assign w_err = (|req_addr[1:0]) | (|req_addr[XLEN-1:AW+2]);
  assign w_idx = req_addr[AW+1:2];

  // NOTE: default assignment first keeps this block purely combinational.
  always_comb begin
    w_credits_nxt = r_credits;
    case ({w_accept, w_pop})
      2'b10:   w_credits_nxt = r_credits + 1'b1;
      2'b01:   w_credits_nxt = r_credits - 1'b1;
      default: w_credits_nxt = r_credits;
    endcase
  end

  // req_ready is registered from next-state credits, so it never sees req_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits   <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_credits   <= w_credits_nxt;
      r_req_ready <= (w_credits_nxt < CW'(MAX_OUTST));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pipe[0].data <= w_err ? '0 : INIT_IMAGE[w_idx];
      r_pipe[0].err  <= w_err;
    end
    for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
  end

  // Credits reserve FIFO space at accept time; the full gate is only a backstop.
  assign w_push = r_pipe_vld[LATENCY-1] & ~w_fifo_full;

  resp_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_pipe[LATENCY-1]),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign resp_valid = ~w_fifo_empty;
  assign resp_data  = w_fifo_empty ? '0 : w_head.data;
  assign resp_err   = ~w_fifo_empty & w_head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected words are queued on accept
// and compared in order as responses are consumed.
module tb_imem_responder;

  localparam logic [31:0] IMG [1024] = '{
    0:  32'h1000_0000, 1:  32'h1000_0001, 2:  32'h1000_0002, 3:  32'h1000_0003,
    4:  32'h0050_0093, 5:  32'h1000_0005, 6:  32'h1000_0006, 7:  32'h1000_0007,
    8:  32'h1000_0008, 9:  32'h1000_0009, 10: 32'h1000_000A, 11: 32'h1000_000B,
    12: 32'h1000_000C, 13: 32'h1000_000D, 14: 32'h1000_000E, 15: 32'h1000_000F,
    1023: 32'hDEAD_BEEF,
    default: 32'h0
  };

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pop_count = 0;
  int   first_pop = 0;
  int   last_pop = 0;
  exp_t sb[$];

  imem_responder #(
    .MEM_WORDS  (1024),
    .LATENCY    (2),
    .MAX_OUTST  (4),
    .INIT_IMAGE (IMG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] img_word(input logic [9:0] idx);
    if (idx == 10'd4)         return 32'h0050_0093;
    else if (idx == 10'd1023) return 32'hDEAD_BEEF;
    else if (idx < 10'd16)    return 32'h1000_0000 + 32'(idx);
    else                      return 32'h0;
  endfunction

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    logic bad;
    bad    = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    e.err  = bad;
    e.data = bad ? 32'h0 : img_word(a[11:2]);
    return e;
  endfunction

  // Handshakes seen at the negedge complete at the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("stale_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_err", 32'(resp_err), 32'(e.err));
        end
        pop_count++;
        if (pop_count == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (req_valid && req_ready) sb.push_back(model(req_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!got && n < 40) begin
      @(negedge clk);
      got = req_ready;
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!got) check("issue_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    resp_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("idle_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    step();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Single fetch and minimum latency
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    step();
    req_valid = 1'b0;
    check("lat_after_n", 32'(resp_valid), 32'd0);
    step();
    check("lat_after_n1", 32'(resp_valid), 32'd0);
    step();
    check("lat_after_n2", 32'(resp_valid), 32'd1);
    check("single_data", resp_data, 32'h0050_0093);
    check("single_err", 32'(resp_err), 32'd0);
    drain();

    // Streaming at full throughput
    pop_count = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      check("stream_ready", 32'(req_ready), 32'd1);
      step();
    end
    req_valid = 1'b0;
    drain();
    check("stream_count", 32'(pop_count), 32'd16);
    check("stream_span", 32'(last_pop - first_pop), 32'd15);

    // Back-pressure: credits cap acceptance at four
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h20 + 32'(i * 4));
    req_valid = 1'b1;
    req_addr  = 32'h30;
    for (int i = 0; i < 4; i++) begin
      check("bp_blocked", 32'(req_ready), 32'd0);
      step();
    end
    check("bp_head_valid", 32'(resp_valid), 32'd1);
    check("bp_head_data", resp_data, 32'h1000_0008);
    resp_ready = 1'b1;
    step();
    check("bp_reassert", 32'(req_ready), 32'd1);
    issue(32'h30);
    issue(32'h34);
    drain();

    // Error responses, then recovery with valid addresses
    issue(32'h6);
    issue(32'h1000);
    issue(32'hFFC);
    issue(32'h10);
    drain();

    // Simultaneous accept and pop with one credit free
    resp_ready = 1'b0;
    issue(32'h0);
    issue(32'h4);
    issue(32'h8);
    n = 0;
    while (!resp_valid && n < 10) begin
      step();
      n++;
    end
    check("sim_resp_valid", 32'(resp_valid), 32'd1);
    req_valid  = 1'b1;
    req_addr   = 32'hC;
    resp_ready = 1'b1;
    check("sim_pre_ready", 32'(req_ready), 32'd1);
    step();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("sim_post_ready", 32'(req_ready), 32'd1);
    issue(32'h3C);
    check("sim_full", 32'(req_ready), 32'd0);
    drain();

    // Reset with three requests in flight
    resp_ready = 1'b0;
    issue(32'h14);
    issue(32'h18);
    issue(32'h1C);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("rel_ready", 32'(req_ready), 32'd1);
    check("rel_valid", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("no_stale", 32'(resp_valid), 32'd0);
    end
    issue(32'h10);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
